// File: rtl/ram1024x8_pkg.sv
// Shared sizes and type definitions for the 1024x8 RAM arbiter slice.
package ram1024x8_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1024;

    typedef enum logic {ST_SERVE, ST_SWEEP} state_t;

    typedef enum logic {CLIENT_A = 1'b0, CLIENT_B = 1'b1} client_t;

endpackage

// File: rtl/ram1024x8_if.sv
// Client-side command/response bundle of the arbiter plus the sweep control pair.
interface ram1024x8_if;
    import ram1024x8_pkg::*;

    logic              init_start;
    logic              init_busy;

    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    modport master (
        output init_start,
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        input  init_busy,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata
    );

    modport slave (
        input  init_start,
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        output init_busy,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata
    );

endinterface

// File: rtl/ram1024x8.sv
// Simple-dual-port 1024x8 block RAM: one write port, one read port with a resettable
// read-data register and no extra output pipeline stage.
module ram1024x8
    import ram1024x8_pkg::*;
(
    input  logic              wr_clk,
    input  logic              wr_rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // The array itself is never cleared; reset only blocks writes.
    always_ff @(posedge wr_clk) begin
        if (wr_en && !wr_rst) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= r_mem[rd_addr];
        end
    end

endmodule

// File: rtl/ram1024x8_arb.sv
// Two-client round-robin arbiter and fill-sweep sequencer in front of the 1024x8 RAM;
// one command per cycle, zero-latency grant, one-cycle read return.
module ram1024x8_arb
    import ram1024x8_pkg::*;
#(
    parameter logic [DATA_W-1:0] FILL_VALUE     = 8'h00,
    parameter bit                CLEAR_ON_RESET = 1'b1
)
(
    input  logic         clk,
    input  logic         rst_n,
    ram1024x8_if.slave   bus
);

    localparam state_t            RST_STATE = CLEAR_ON_RESET ? ST_SWEEP : ST_SERVE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_swp_addr;
    client_t           r_last;
    logic              r_rsp_valid;
    client_t           r_rsp_id;

    logic              w_serve;
    logic              w_sweep;
    logic              w_a_win;
    logic              w_b_win;
    logic              w_gnt_any;
    client_t           w_win_id;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;
    logic              w_rd_fire;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic [DATA_W-1:0] w_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SERVE: if (bus.init_start)            w_state_nxt = ST_SWEEP;
            ST_SWEEP: if (r_swp_addr == LAST_ADDR)    w_state_nxt = ST_SERVE;
            default:                                  w_state_nxt = RST_STATE;
        endcase
    end

    // The counter wraps to zero after the last address, so it is ready for the next sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_swp_addr <= '0;
        end else if (r_state == ST_SWEEP) begin
            r_swp_addr <= r_swp_addr + 1'b1;
        end else if (bus.init_start) begin
            r_swp_addr <= '0;
        end
    end

    assign w_serve = (r_state == ST_SERVE);
    assign w_sweep = (r_state == ST_SWEEP);

    // On a contest the client that was not granted most recently wins.
    assign w_a_win   = bus.a_req & (~bus.b_req | (r_last == CLIENT_B));
    assign w_b_win   = bus.b_req & (~bus.a_req | (r_last == CLIENT_A));
    assign w_gnt_any = w_serve & (w_a_win | w_b_win);
    assign w_win_id  = w_b_win ? CLIENT_B : CLIENT_A;

    assign w_win_we    = (w_win_id == CLIENT_B) ? bus.b_we    : bus.a_we;
    assign w_win_addr  = (w_win_id == CLIENT_B) ? bus.b_addr  : bus.a_addr;
    assign w_win_wdata = (w_win_id == CLIENT_B) ? bus.b_wdata : bus.a_wdata;
    assign w_rd_fire   = w_gnt_any & ~w_win_we;

    assign w_wr_en   = w_sweep | (w_gnt_any & w_win_we);
    assign w_wr_addr = w_sweep ? r_swp_addr : w_win_addr;
    assign w_wr_data = w_sweep ? FILL_VALUE : w_win_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= CLIENT_B;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= CLIENT_A;
        end else begin
            r_rsp_valid <= w_rd_fire;
            if (w_gnt_any) begin
                r_last <= w_win_id;
            end
            if (w_rd_fire) begin
                r_rsp_id <= w_win_id;
            end
        end
    end

    assign bus.init_busy = w_sweep;
    assign bus.a_gnt     = w_serve & w_a_win;
    assign bus.b_gnt     = w_serve & w_b_win;
    assign bus.a_rvalid  = r_rsp_valid & (r_rsp_id == CLIENT_A);
    assign bus.b_rvalid  = r_rsp_valid & (r_rsp_id == CLIENT_B);
    assign bus.a_rdata   = w_rd_data;
    assign bus.b_rdata   = w_rd_data;

    ram1024x8 u_ram (
        .wr_clk  (clk),
        .wr_rst  (~rst_n),
        .wr_en   (w_wr_en),
        .wr_addr (w_wr_addr),
        .wr_data (w_wr_data),
        .rd_clk  (clk),
        .rd_rst  (~rst_n),
        .rd_addr (w_win_addr),
        .rd_data (w_rd_data)
    );

endmodule
